apb_mem_arbiter: RTL and testbench

Two-requester arbiter and APB master sequencer that shares one APB memory slave (`mem_apb`-style, AMBA3 with PREADY/PSLVERR, AMBA4 PSTRB/PPROT) between two on-chip requesters. Each requester issues single 32-bit read/write commands over a valid/ready port. The block grants round-robin, runs the APB SETUP/ACCESS sequence with wait states, and returns read data or an error on a one-cycle response strobe. A programmable timeout aborts transfers whose PREADY never arrives.

---
 rtl/apb_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_apb_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// apb_mem_arbiter
//
// Shares one APB slave between two on-chip requesters. Each requester issues
// single 32-bit read/write commands on a valid/ready port. Ties are broken
// round-robin, the APB SETUP/ACCESS sequence is run with wait-state support,
// and the result comes back on a one-cycle response strobe.
//
// Parameters
//   TIMEOUT      PREADY-low ACCESS cycles tolerated before abort (0 = never)
//
// Ports
//   PCLK, PRESETn                 clock, async active-low reset
//   req{0,1}_valid/_write/_addr/_wdata/_strb   command in
//   req{0,1}_ready                command accepted (combinational)
//   rsp{0,1}_valid/_rdata/_err    one-cycle response; rdata/err hold
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT   APB master outputs
//   PRDATA, PREADY, PSLVERR       APB slave returns
// ---------------------------------------------------------------------------
module apb_mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_strb,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_strb,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  output logic [2:0]  PPROT,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state;
  logic        last_grant;  // requester granted most recently
  logic        owner;       // requester that owns the in-flight transfer
  logic [31:0] wait_cnt;    // PREADY-low ACCESS cycles already elapsed

  logic        grant1;      // 1: requester 1 is the candidate this cycle
  logic        timeout_hit;
  logic        done;
  logic [31:0] done_rdata;
  logic        done_err;

  // On a tie the requester that was not served last wins; otherwise the
  // lone valid requester is the candidate.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant1 = 1'b0;
    if (req0_valid && req1_valid) grant1 = ~last_grant;
    else                          grant1 = req1_valid;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant1;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant1;
  assign PPROT      = 3'h0;

  // The abort fires on the ACCESS cycle that follows TIMEOUT wait cycles,
  // so the error response lands TIMEOUT+3 cycles after the handshake.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TIMEOUT);

  always_comb begin
    done       = 1'b0;
    done_rdata = 32'h0;
    done_err   = 1'b0;
    if (state == ACCESS) begin
      if (PREADY) begin
        done       = 1'b1;
        done_rdata = PWRITE ? 32'h0 : PRDATA;
        done_err   = PSLVERR;
      end else if (timeout_hit) begin
        done       = 1'b1;
        done_err   = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      wait_cnt   <= 32'h0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= 32'h0;
      PWDATA     <= 32'h0;
      PSTRB      <= 4'h0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= 32'h0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= 32'h0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            PADDR      <= grant1 ? req1_addr  : req0_addr;
            PWRITE     <= grant1 ? req1_write : req0_write;
            PWDATA     <= grant1 ? req1_wdata : req0_wdata;
            // Strobes are meaningless on reads and are driven to zero there.
            PSTRB      <= grant1 ? (req1_write ? req1_strb : 4'h0)
                                 : (req0_write ? req0_strb : 4'h0);
            owner      <= grant1;
            last_grant <= grant1;
            PSEL       <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= 32'h0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state   <= IDLE;
            if (owner) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= done_rdata;
              rsp1_err   <= done_err;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= done_rdata;
              rsp0_err   <= done_err;
            end
          end else begin
            wait_cnt <= wait_cnt + 32'h1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_mem_arbiter
//
// Directed bench for apb_mem_arbiter (TIMEOUT = 4). A small APB slave model
// with a 16-word byte-strobed memory, programmable wait states, error and
// hang controls sits on the APB side. Each scenario task drives its own
// stimulus and checks hand-computed expectations at negative clock edges.
// ---------------------------------------------------------------------------
module tb_apb_mem_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic [3:0]  req0_strb, req1_strb;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;

  int n_cmp  = 0;
  int n_fail = 0;

  // slave model controls
  int          wait_states = 0;
  logic        hang    = 1'b0;
  logic        slv_err = 1'b0;
  int          acc_cnt = 0;
  logic [31:0] mem [0:15];

  always #5 PCLK = ~PCLK;

  apb_mem_arbiter #(.TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_strb(req0_strb), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_strb(req1_strb), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // APB slave model
  assign PREADY  = PSEL && PENABLE && !hang && (acc_cnt >= wait_states);
  assign PSLVERR = slv_err && PREADY;
  assign PRDATA  = mem[PADDR[5:2]];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE) begin
      for (int b = 0; b < 4; b++)
        if (PSTRB[b]) mem[PADDR[5:2]][8*b +: 8] <= PWDATA[8*b +: 8];
    end
  end

  // Drives one command on a port, waits for the handshake and the response.
  // lat = cycles from handshake to rsp_valid (-1 if no handshake/response).
  task automatic run_cmd(input bit port, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         output int lat, output logic [31:0] rdata,
                         output logic err, output logic stray,
                         output logic [3:0] setup_strb, output logic psel_at_rsp);
    int tries;
    int c;
    lat = -1; rdata = 32'h0; err = 1'b0; stray = 1'b0;
    setup_strb = 4'h0; psel_at_rsp = 1'b1;
    @(negedge PCLK);
    if (port) begin
      req1_valid = 1'b1; req1_write = wr; req1_addr = addr;
      req1_wdata = wdata; req1_strb = strb;
    end else begin
      req0_valid = 1'b1; req0_write = wr; req0_addr = addr;
      req0_wdata = wdata; req0_strb = strb;
    end
    #1;
    tries = 0;
    while (!(port ? req1_ready : req0_ready) && tries < 20) begin
      @(negedge PCLK); #1; tries++;
    end
    if (tries >= 20) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    @(negedge PCLK);
    req0_valid = 1'b0; req1_valid = 1'b0;
    setup_strb = PSTRB;
    c = 1;
    while (c < 30) begin
      if (port ? rsp0_valid : rsp1_valid) stray = 1'b1;
      if (port ? rsp1_valid : rsp0_valid) begin
        lat = c;
        rdata = port ? rsp1_rdata : rsp0_rdata;
        err = port ? rsp1_err : rsp0_err;
        psel_at_rsp = PSEL;
        break;
      end
      @(negedge PCLK);
      c++;
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0; req0_strb = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0; req1_strb = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    repeat (2) @(negedge PCLK);
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000", {PSEL, PENABLE, PWRITE});
    end
    n_cmp++;
    if ({PADDR, PWDATA, PSTRB, PPROT} !== 71'h0) begin
      n_fail++; $display("FAIL reset_bus: got %h/%h/%h/%h want 0", PADDR, PWDATA, PSTRB, PPROT);
    end
    n_cmp++;
    if ({rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata} !== 68'h0) begin
      n_fail++; $display("FAIL reset_rsp: got %b %b %h %b %b %h want all 0",
                         rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata);
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
  endtask

  task automatic test_round_robin();
    int g[$];
    int q[$];
    int exp_g[4] = '{0, 1, 0, 1};
    int exp_owner;
    int n0 = 0, n1 = 0;
    req0_write = 1; req0_addr = 32'h20; req0_wdata = 32'h0000_0001; req0_strb = 4'hF;
    req1_write = 1; req1_addr = 32'h24; req1_wdata = 32'h0000_0002; req1_strb = 4'hF;
    req0_valid = 1; req1_valid = 1;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (g.size() == 4) begin req0_valid = 0; req1_valid = 0; end
      if (rsp0_valid || rsp1_valid) begin
        exp_owner = (q.size() > 0) ? q.pop_front() : -1;
        if (rsp0_valid) n0++;
        if (rsp1_valid) n1++;
        n_cmp++;
        if ({rsp1_valid, rsp0_valid} !== ((exp_owner == 1) ? 2'b10 : 2'b01) || exp_owner < 0) begin
          n_fail++; $display("FAIL rr_route: got rsp1/rsp0=%b want owner %0d",
                             {rsp1_valid, rsp0_valid}, exp_owner);
        end
      end
      if (g.size() < 4 && req0_ready) begin g.push_back(0); q.push_back(0); end
      else if (g.size() < 4 && req1_ready) begin g.push_back(1); q.push_back(1); end
      if (g.size() == 4 && q.size() == 0) break;
      @(negedge PCLK); #1;
    end
    n_cmp++;
    if (g.size() != 4) begin
      n_fail++; $display("FAIL rr_grants: got %0d grants want 4", g.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (g[i] != exp_g[i]) begin
          n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, g[i], exp_g[i]);
        end
      end
    end
    n_cmp++;
    if (n0 != 2 || n1 != 2) begin
      n_fail++; $display("FAIL rr_counts: got %0d/%0d want 2/2", n0, n1);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er, st, ps; logic [3:0] ss;
    @(negedge PCLK);
    req0_valid = 1; req0_write = 1; req0_addr = 32'h10;
    req0_wdata = 32'hDEAD_BEEF; req0_strb = 4'hF;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL wr_ready: got %b want 10", {req0_ready, req1_ready});
    end
    @(negedge PCLK);  // cycle 1: SETUP
    req0_valid = 0;
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB} !== {3'b101, 32'h10, 32'hDEAD_BEEF, 4'hF}) begin
      n_fail++; $display("FAIL wr_setup: got %b%b%b %h %h %h", PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB);
    end
    @(negedge PCLK);  // cycle 2: ACCESS
    n_cmp++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      n_fail++; $display("FAIL wr_access: got %b want 11", {PSEL, PENABLE});
    end
    @(negedge PCLK);  // cycle 3: response
    n_cmp++;
    if ({rsp0_valid, rsp0_err, rsp0_rdata, PSEL} !== {2'b10, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL wr_rsp: got v%b e%b d%h psel%b want v1 e0 d0 psel0",
                         rsp0_valid, rsp0_err, rsp0_rdata, PSEL);
    end
    run_cmd(0, 0, 32'h10, 32'h0, 4'hF, lat, rd, er, st, ss, ps);
    n_cmp++;
    if (lat != 3 || rd !== 32'hDEAD_BEEF || er !== 1'b0 || st !== 1'b0) begin
      n_fail++; $display("FAIL rd_rsp: got lat %0d d%h e%b stray%b want 3 deadbeef 0 0", lat, rd, er, st);
    end
  endtask

  task automatic test_wait_states();
    logic [1:0] exp_ctl [1:6] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    wait_states = 3;
    @(negedge PCLK);
    req0_valid = 1; req0_write = 0; req0_addr = 32'h10; req0_strb = 4'hF;
    @(negedge PCLK);
    req0_valid = 0;
    for (int c = 1; c <= 6; c++) begin
      n_cmp++;
      if ({PSEL, PENABLE} !== exp_ctl[c] || (c < 6 && PADDR !== 32'h10) ||
          rsp0_valid !== (c == 6)) begin
        n_fail++; $display("FAIL wait_c%0d: got ctl %b addr %h rsp %b want ctl %b addr 10 rsp %b",
                           c, {PSEL, PENABLE}, PADDR, rsp0_valid, exp_ctl[c], (c == 6));
      end
      if (c == 6) begin
        n_cmp++;
        if (rsp0_rdata !== 32'hDEAD_BEEF || rsp0_err !== 1'b0) begin
          n_fail++; $display("FAIL wait_data: got %h e%b want deadbeef e0", rsp0_rdata, rsp0_err);
        end
      end
      if (c < 6) @(negedge PCLK);
    end
    wait_states = 0;
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er, st, ps; logic [3:0] ss;
    run_cmd(1, 0, 32'h10, 32'h0, 4'h0, lat, rd, er, st, ss, ps);
    @(negedge PCLK);
    n_cmp++;
    if (lat != 3 || rsp1_rdata !== 32'hDEAD_BEEF || rsp1_valid !== 1'b0) begin
      n_fail++; $display("FAIL rsp1_hold: got lat %0d d%h v%b want 3 deadbeef 0", lat, rsp1_rdata, rsp1_valid);
    end
    slv_err = 1;
    run_cmd(1, 1, 32'h30, 32'h1234_5678, 4'hF, lat, rd, er, st, ss, ps);
    slv_err = 0;
    n_cmp++;
    if (lat != 3 || er !== 1'b1 || rd !== 32'h0 || st !== 1'b0) begin
      n_fail++; $display("FAIL slverr: got lat %0d e%b d%h stray%b want 3 1 0 0", lat, er, rd, st);
    end
    hang = 1;
    run_cmd(0, 0, 32'h10, 32'h0, 4'h0, lat, rd, er, st, ss, ps);
    hang = 0;
    n_cmp++;
    if (lat != 7 || er !== 1'b1 || rd !== 32'h0 || ps !== 1'b0) begin
      n_fail++; $display("FAIL timeout: got lat %0d e%b d%h psel%b want 7 1 0 0", lat, er, rd, ps);
    end
  endtask

  task automatic test_strobes();
    int lat; logic [31:0] rd; logic er, st, ps; logic [3:0] ss;
    run_cmd(0, 1, 32'h40, 32'hA5A5_A5A5, 4'b0101, lat, rd, er, st, ss, ps);
    n_cmp++;
    if (ss !== 4'b0101 || PPROT !== 3'h0 || lat != 3) begin
      n_fail++; $display("FAIL strb_wr: got pstrb %b pprot %h lat %0d want 0101 0 3", ss, PPROT, lat);
    end
    run_cmd(0, 0, 32'h40, 32'h0, 4'hF, lat, rd, er, st, ss, ps);
    n_cmp++;
    if (ss !== 4'h0 || rd !== 32'h00A5_00A5 || PPROT !== 3'h0) begin
      n_fail++; $display("FAIL strb_rd: got pstrb %b d%h pprot %h want 0 00a500a5 0", ss, rd, PPROT);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    hang = 1;
    @(negedge PCLK);
    req0_valid = 1; req0_write = 0; req0_addr = 32'h10;
    @(negedge PCLK);
    req0_valid = 0;
    repeat (3) @(negedge PCLK);  // cycle 4, mid-wait
    PRESETn = 1'b0;
    #1;
    n_cmp++;
    if ({PSEL, PENABLE, PADDR} !== 34'h0) begin
      n_fail++; $display("FAIL rst_async: got psel %b pen %b addr %h want 0", PSEL, PENABLE, PADDR);
    end
    seen = 0;
    repeat (3) begin
      @(negedge PCLK);
      if (rsp0_valid || rsp1_valid) seen++;
    end
    hang = 0;
    PRESETn = 1'b1;
    repeat (2) begin
      @(negedge PCLK);
      if (rsp0_valid || rsp1_valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rst_norsp: got %0d responses want 0", seen);
    end
    req0_valid = 1; req1_valid = 1; req0_write = 0; req1_write = 0;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL rst_tie: got ready0/1 %b want 10", {req0_ready, req1_ready});
    end
    @(negedge PCLK);
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(negedge PCLK);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_read();
    test_wait_states();
    test_errors();
    test_strobes();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
